// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory responder.
// Holds the FSM encoding, default latencies and the counter sizing helper.
package cache_mem_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_READ  = 2'd1;
    localparam logic [1:0] ENC_WRITE = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_READ  = ENC_READ,
        ST_WRITE = ENC_WRITE,
        ST_DONE  = ENC_DONE
    } state_t;

    localparam int DEF_READ_LATENCY  = 50;
    localparam int DEF_WRITE_LATENCY = 50;

    function automatic int cnt_width(input int rl, input int wl);
        return $clog2(((rl > wl) ? rl : wl) + 1);
    endfunction

endpackage

// File: rtl/memory_array_sp.sv
// Single-port backing word store: synchronous write, registered read.
// Addresses at or beyond SIZE drop writes and read back as zero.
module memory_array_sp #(
    parameter int SIZE          = 4096,
    parameter int ADDRESS_SPACE = 12,
    parameter int DATA_SIZE     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDRESS_SPACE-1:0] addr,
    input  logic [DATA_SIZE-1:0]     wdata,
    output logic [DATA_SIZE-1:0]     rdata
);

    logic [DATA_SIZE-1:0] mem [SIZE];
    logic                 in_range;

    generate
        if (SIZE < (2 ** ADDRESS_SPACE)) begin : g_partial
            assign in_range = ({1'b0, addr} < (ADDRESS_SPACE+1)'(SIZE));
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/cache_memory_responder.sv
// Memory-side responder for cache refill and write-back requests.
// One request at a time; latency modelled with a down-counter.
module cache_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int SIZE          = 4096,
    parameter int ADDRESS_SPACE = 12,
    parameter int DATA_SIZE     = 32,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
    input  logic                     clk,
    input  logic                     rsta,
    input  logic                     fetch,
    input  logic                     flush,
    input  logic [ADDRESS_SPACE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]     flush_data,
    output logic                     fetch_ack,
    output logic                     flush_ack,
    output logic [DATA_SIZE-1:0]     fetch_data,
    output logic                     busy,
    input  logic                     load_we,
    input  logic [ADDRESS_SPACE-1:0] load_addr,
    input  logic [DATA_SIZE-1:0]     load_data
);

    localparam int CW = cnt_width(READ_LATENCY, WRITE_LATENCY);

    state_t                   state, state_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [ADDRESS_SPACE-1:0] lat_addr, lat_addr_n;
    logic [DATA_SIZE-1:0]     lat_data, lat_data_n;
    logic                     svc_flush, svc_flush_n;
    logic                     fetch_ack_n, flush_ack_n;
    logic [DATA_SIZE-1:0]     fetch_data_n;

    logic                     mem_we, mem_re;
    logic [ADDRESS_SPACE-1:0] mem_addr;
    logic [DATA_SIZE-1:0]     mem_wdata, mem_rdata;

    memory_array_sp #(
        .SIZE          (SIZE),
        .ADDRESS_SPACE (ADDRESS_SPACE),
        .DATA_SIZE     (DATA_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rsta) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            svc_flush  <= 1'b0;
            fetch_ack  <= 1'b0;
            flush_ack  <= 1'b0;
            fetch_data <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_addr   <= lat_addr_n;
            lat_data   <= lat_data_n;
            svc_flush  <= svc_flush_n;
            fetch_ack  <= fetch_ack_n;
            flush_ack  <= flush_ack_n;
            fetch_data <= fetch_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lat_addr_n   = lat_addr;
        lat_data_n   = lat_data;
        svc_flush_n  = svc_flush;
        fetch_ack_n  = 1'b0;
        flush_ack_n  = 1'b0;
        fetch_data_n = fetch_data;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = load_addr;
        mem_wdata    = load_data;

        unique case (state)
            ST_IDLE: begin
                if (flush) begin
                    lat_addr_n  = req_addr;
                    lat_data_n  = flush_data;
                    svc_flush_n = 1'b1;
                    cnt_n       = CW'(WRITE_LATENCY - 1);
                    state_n     = ST_WRITE;
                end else if (fetch) begin
                    lat_addr_n  = req_addr;
                    svc_flush_n = 1'b0;
                    mem_re      = 1'b1;
                    mem_addr    = req_addr;
                    cnt_n       = CW'(READ_LATENCY - 1);
                    state_n     = ST_READ;
                end else if (load_we) begin
                    mem_we = 1'b1;
                end
            end
            ST_READ: begin
                if (cnt == CW'(1)) begin
                    fetch_ack_n  = 1'b1;
                    fetch_data_n = mem_rdata;
                    cnt_n        = '0;
                    state_n      = ST_DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_WRITE: begin
                mem_addr  = lat_addr;
                mem_wdata = lat_data;
                if (cnt == CW'(1)) begin
                    mem_we      = 1'b1;
                    flush_ack_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = ST_DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                // Wait for the serviced request to drop so it is acked once.
                if (svc_flush ? !flush : !fetch) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (rsta) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_memory_responder.sv
// Scoreboard bench for cache_memory_responder: expected acks are queued
// when requests are driven and checked when the DUT acknowledges.
module tb_cache_memory_responder;

    localparam int RL = 50;
    localparam int WL = 50;
    localparam int BOUND = 200;

    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rsta;
    logic        fetch, flush;
    logic [11:0] req_addr;
    logic [31:0] flush_data;
    logic        fetch_ack, flush_ack;
    logic [31:0] fetch_data;
    logic        busy;
    logic        load_we;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cache_memory_responder #(
        .SIZE          (4096),
        .ADDRESS_SPACE (12),
        .DATA_SIZE     (32),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk        (clk),
        .rsta       (rsta),
        .fetch      (fetch),
        .flush      (flush),
        .req_addr   (req_addr),
        .flush_data (flush_data),
        .fetch_ack  (fetch_ack),
        .flush_ack  (flush_ack),
        .fetch_data (fetch_data),
        .busy       (busy),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every ack must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (fetch_ack || flush_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {fetch_ack, flush_ack}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_kind", {fetch_ack, flush_ack},
                      e.is_fetch ? 2'b10 : 2'b01);
                if (e.is_fetch) check("fetch_data", fetch_data, e.data);
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic txn(input bit is_f, input logic [11:0] a,
                       input logic [31:0] d, input int hold,
                       input bit poke);
        int  n;
        bit  acked;
        exp_t e;
        e.is_fetch = is_f;
        e.data = d;
        sb.push_back(e);
        @(negedge clk);
        req_addr = a; flush_data = d;
        if (is_f) fetch = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        check("busy_accept", busy, 1'b1);
        req_addr = ~a; flush_data = ~d;
        n = 0; acked = 0;
        while (!acked && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 2) begin
                load_we = 1'b1; load_addr = a; load_data = 32'h0BAD0BAD;
            end
            if (poke && n == 3) load_we = 1'b0;
            if (is_f ? fetch_ack : flush_ack) acked = 1;
        end
        check(is_f ? "fetch_latency" : "flush_latency", n,
              is_f ? RL - 1 : WL - 1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("busy_held", busy, 1'b1);
        end
        if (is_f) check("data_held", fetch_data, d);
        @(negedge clk);
        fetch = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check("busy_release", busy, 1'b0);
        check("acks_low", {fetch_ack, flush_ack}, 2'b00);
    endtask

    initial begin
        int n;
        rsta = 1'b1; fetch = 1'b0; flush = 1'b0;
        req_addr = '0; flush_data = '0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {fetch_ack, flush_ack, busy, fetch_data},
              35'd0);
        rsta = 1'b0;

        preload(12'h050, 32'h11111111);
        @(negedge clk);
        rsta = 1'b1;
        load_we = 1'b1; load_addr = 12'h050; load_data = 32'hBADBADBA;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        rsta = 1'b0; load_we = 1'b0;
        txn(1'b1, 12'h050, 32'h11111111, 0, 1'b0);

        preload(12'h010, 32'hDEADBEEF);
        txn(1'b1, 12'h010, 32'hDEADBEEF, 0, 1'b0);

        txn(1'b0, 12'h020, 32'hCAFEF00D, 0, 1'b0);
        txn(1'b1, 12'h020, 32'hCAFEF00D, 0, 1'b0);

        // Simultaneous request: flush first, then fetch of the new data.
        begin
            exp_t e;
            e.is_fetch = 1'b0; e.data = 32'h12345678; sb.push_back(e);
            e.is_fetch = 1'b1; e.data = 32'h12345678; sb.push_back(e);
        end
        @(negedge clk);
        req_addr = 12'h030; flush_data = 32'h12345678;
        fetch = 1'b1; flush = 1'b1;
        n = 0;
        while (!flush_ack && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("sim_flush_ack", flush_ack, 1'b1);
        check("sim_no_fetch_yet", fetch_ack, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (!fetch_ack && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("sim_fetch_ack", fetch_ack, 1'b1);
        @(negedge clk);
        fetch = 1'b0;
        @(posedge clk); #1;
        check("sim_idle", busy, 1'b0);

        // Reset partway through a write-back aborts it silently.
        preload(12'h040, 32'h0);
        @(negedge clk);
        req_addr = 12'h040; flush_data = 32'hFFFFFFFF; flush = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rsta = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 1'b0);
        check("abort_acks", {fetch_ack, flush_ack}, 2'b00);
        check("abort_data", fetch_data, 32'h0);
        @(negedge clk);
        rsta = 1'b0;
        repeat (60) @(posedge clk);
        txn(1'b1, 12'h040, 32'h0, 0, 1'b0);

        // Held fetch gives one ack; preload while busy is ignored.
        preload(12'h060, 32'hA5A5A5A5);
        txn(1'b1, 12'h060, 32'hA5A5A5A5, 10, 1'b1);
        txn(1'b1, 12'h060, 32'hA5A5A5A5, 0, 1'b0);

        repeat (5) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
